// File: rtl/ppuvmem_pkg.sv
// Shared definitions for the PPU video-memory responder.
// Build option: PPUVMEM_FOURSCREEN_EN (4 KB nametable RAM, four-screen on mode 3).
package ppuvmem_pkg;

    // Nametable mirroring modes as driven by the cartridge.
    localparam logic [1:0] MIR_HORZ    = 2'd0;
    localparam logic [1:0] MIR_VERT    = 2'd1;
    localparam logic [1:0] MIR_SINGLE0 = 2'd2;
    localparam logic [1:0] MIR_SINGLE1 = 2'd3;

    // Responder FSM states.
    localparam logic [1:0] ST_IDLE    = 2'd0;
    localparam logic [1:0] ST_NTRD    = 2'd1;
    localparam logic [1:0] ST_CHRWAIT = 2'd2;

`ifdef PPUVMEM_FOURSCREEN_EN
    localparam int NT_AW = 12;
`else
    localparam int NT_AW = 11;
`endif

    // Map a nametable address onto the on-chip RAM according to the mirroring mode.
    function automatic logic [NT_AW-1:0] nt_index(input logic [13:0] addr, input logic [1:0] mir);
        logic page;
        case (mir)
            MIR_HORZ:    page = addr[11];
            MIR_VERT:    page = addr[10];
            MIR_SINGLE0: page = 1'b0;
            default:     page = 1'b1;
        endcase
`ifdef PPUVMEM_FOURSCREEN_EN
        if (mir == MIR_SINGLE1) begin
            nt_index = addr[11:0];
        end else begin
            nt_index = {1'b0, page, addr[9:0]};
        end
`else
        nt_index = {page, addr[9:0]};
`endif
    endfunction

endpackage

// File: rtl/ppuvmem_vram_nt.sv
// Single-port nametable RAM with a registered read port. Contents are not reset.
module ppuvmem_vram_nt #(
    parameter int AW = 11
) (
    input  logic          clk,
    input  logic          we_i,
    input  logic [AW-1:0] addr_i,
    input  logic [7:0]    wdata_i,
    output logic [7:0]    rdata_o
);

    logic [7:0] mem [0:(1<<AW)-1];
    logic [7:0] rdata_q;

    // Synchronous write and registered read; read-during-write ordering is not relied on.
    always_ff @(posedge clk) begin
        if (we_i) begin
            mem[addr_i] <= wdata_i;
        end
        rdata_q <= mem[addr_i];
    end

    assign rdata_o = rdata_q;

endmodule

// File: rtl/ppuvmem.sv
// PPU video-memory responder: pattern-table traffic goes to the cartridge CHR
// port, nametable traffic to on-chip RAM with cartridge-selected mirroring.
// Handshake: a request is taken when vmemreq is high in IDLE and vmemack is low
// (the initiator keeps vmemreq up during the ack cycle); each accepted request
// produces exactly one single-cycle vmemack, with vmemrdata valid from then on.
// CHR side: chrreq is held until a chrack pulse or until CHR_TIMEOUT wait cycles
// elapse, in which case reads complete with 8'hFF.
// Build option: PPUVMEM_FOURSCREEN_EN.
module ppuvmem
    import ppuvmem_pkg::*;
#(
    parameter int CHR_TIMEOUT = 255
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [13:0] vmemaddr,
    input  logic [7:0]  vmemwdata,
    input  logic        vmemwr,
    input  logic        vmemreq,
    output logic        vmemack,
    output logic [7:0]  vmemrdata,
    input  logic [1:0]  mirror,
    output logic [12:0] chraddr,
    output logic [7:0]  chrwdata,
    output logic        chrwr,
    output logic        chrreq,
    input  logic        chrack,
    input  logic [7:0]  chrrdata
);

    localparam logic [7:0] TIMEOUT_LAST = 8'(CHR_TIMEOUT - 1);

    logic [1:0]       state_q, state_d;
    logic [7:0]       cnt_q, cnt_d;
    logic             ack_q, ack_d;
    logic [7:0]       rdata_q, rdata_d;
    logic             chrreq_q, chrreq_d;
    logic             chrwr_q, chrwr_d;
    logic [12:0]      chraddr_q, chraddr_d;
    logic [7:0]       chrwdata_q, chrwdata_d;

    logic             accept;
    logic             is_nt;
    logic             ram_we;
    logic [NT_AW-1:0] ram_addr;
    logic [7:0]       ram_rdata;

    assign accept   = (state_q == ST_IDLE) && vmemreq && !ack_q;
    assign is_nt    = vmemaddr[13];
    assign ram_we   = accept && is_nt && vmemwr;
    // Mirror is only meaningful at the acceptance edge; the RAM address is taken there.
    assign ram_addr = nt_index(vmemaddr, mirror);

    ppuvmem_vram_nt #(
        .AW(NT_AW)
    ) u_vram (
        .clk    (clk),
        .we_i   (ram_we),
        .addr_i (ram_addr),
        .wdata_i(vmemwdata),
        .rdata_o(ram_rdata)
    );

    // Next-state logic for the request FSM, CHR port and completion outputs.
    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        ack_d      = 1'b0;
        rdata_d    = rdata_q;
        chrreq_d   = chrreq_q;
        chrwr_d    = chrwr_q;
        chraddr_d  = chraddr_q;
        chrwdata_d = chrwdata_q;
        case (state_q)
            ST_IDLE: begin
                if (accept) begin
                    if (is_nt) begin
                        if (vmemwr) begin
                            ack_d = 1'b1;
                        end else begin
                            state_d = ST_NTRD;
                        end
                    end else begin
                        chrreq_d   = 1'b1;
                        chraddr_d  = vmemaddr[12:0];
                        chrwr_d    = vmemwr;
                        chrwdata_d = vmemwdata;
                        cnt_d      = 8'd0;
                        state_d    = ST_CHRWAIT;
                    end
                end
            end
            ST_NTRD: begin
                rdata_d = ram_rdata;
                ack_d   = 1'b1;
                state_d = ST_IDLE;
            end
            ST_CHRWAIT: begin
                // chrack takes priority over a timeout landing in the same cycle.
                if (chrack) begin
                    chrreq_d = 1'b0;
                    chrwr_d  = 1'b0;
                    if (!chrwr_q) begin
                        rdata_d = chrrdata;
                    end
                    ack_d   = 1'b1;
                    state_d = ST_IDLE;
                end else if (cnt_q == TIMEOUT_LAST) begin
                    chrreq_d = 1'b0;
                    chrwr_d  = 1'b0;
                    if (!chrwr_q) begin
                        rdata_d = 8'hFF;
                    end
                    ack_d   = 1'b1;
                    state_d = ST_IDLE;
                end else begin
                    cnt_d = cnt_q + 8'd1;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // State registers; an asynchronous reset abandons any transaction in flight.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= ST_IDLE;
            cnt_q      <= 8'd0;
            ack_q      <= 1'b0;
            rdata_q    <= 8'd0;
            chrreq_q   <= 1'b0;
            chrwr_q    <= 1'b0;
            chraddr_q  <= 13'd0;
            chrwdata_q <= 8'd0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            ack_q      <= ack_d;
            rdata_q    <= rdata_d;
            chrreq_q   <= chrreq_d;
            chrwr_q    <= chrwr_d;
            chraddr_q  <= chraddr_d;
            chrwdata_q <= chrwdata_d;
        end
    end

    assign vmemack   = ack_q;
    assign vmemrdata = rdata_q;
    assign chrreq    = chrreq_q;
    assign chrwr     = chrwr_q;
    assign chraddr   = chraddr_q;
    assign chrwdata  = chrwdata_q;

endmodule

// File: doc/ppuvmem.md
Name: ppuvmem

Overview:
- Responder end of the PPU video-memory request/acknowledge bus.
- Serves 14-bit `vmem` requests from the background/sprite fetch logic and user `$2007` traffic.
- Decodes the PPU address space:
  - pattern tables ($0000-$1FFF) are forwarded to the cartridge CHR port;
  - nametables ($2000-$3FFF, $3000+ mirrors $2000+) live in on-chip RAM with cartridge-selected mirroring.
- Returns read data with a single-cycle acknowledge.

Parameters:
- CHR_TIMEOUT, 255, cycles waited for `chrack` before forcing a completion with data 8'hFF (8-bit counter; must be at most 255).

Ports:
- clk  input  1  system clock
- reset  input  1  asynchronous active-high reset
- vmemaddr  input  14  request address, valid while vmemreq high
- vmemwdata  input  8  write data, valid while vmemreq && vmemwr
- vmemwr  input  1  1 = write, 0 = read
- vmemreq  input  1  level request, held by initiator until it sees vmemack
- vmemack  output  1  one-cycle completion pulse
- vmemrdata  output  8  read data, valid in the vmemack cycle and held until the next ack
- mirror  input  2  nametable mirroring mode, `MIRHORZ / `MIRVERT / `MIRSINGLE0 / `MIRSINGLE1
- chraddr  output  13  CHR address
- chrwdata  output  8  CHR write data
- chrwr  output  1  CHR write strobe qualifier
- chrreq  output  1  CHR request level
- chrack  input  1  CHR completion pulse, only legal while chrreq is high
- chrrdata  input  8  CHR read data, valid with chrack

Behaviour:
- Reset values:
  - vmemack = 0, vmemrdata = 0;
  - chrreq = 0, chrwr = 0, chraddr = 0, chrwdata = 0;
  - state = IDLE, timeout counter = 0.
  - Nametable RAM contents are not cleared.
- States: IDLE, NTRD, CHRWAIT.
- Acceptance in IDLE requires vmemreq && !vmemack.
  - The guard blocks re-acceptance in the ack cycle, because the initiator drops its request one cycle after ack.
  - On acceptance, latch address, wr and wdata.
- Nametable path (addr[13] = 1):
  - RAM index = {page, addr[9:0]};
    - page = addr[10] for `MIRVERT;
    - page = addr[11] for `MIRHORZ;
    - page = 0 for `MIRSINGLE0;
    - page = 1 for `MIRSINGLE1.
  - Mirror is sampled at acceptance.
  - Write: RAM written at the acceptance edge; vmemack pulses on the next cycle (latency 1); state stays IDLE.
  - Read: RAM read registered at the acceptance edge; state goes to NTRD; the next edge loads vmemrdata and pulses vmemack (latency 2); then back to IDLE.
- CHR path (addr[13] = 0):
  - On acceptance: chrreq = 1, chraddr = addr[12:0], chrwr and chrwdata driven; state goes to CHRWAIT; counter cleared.
  - In CHRWAIT, on chrack:
    - drop chrreq;
    - on reads, vmemrdata <= chrrdata (vmemrdata is unchanged on writes);
    - vmemack = 1 next cycle;
    - return to IDLE.
  - Counter increments each CHRWAIT cycle without chrack. Reaching CHR_TIMEOUT forces completion: chrreq drops, vmemrdata = 8'hFF on reads, vmemack pulses, return to IDLE.
  - If chrack and timeout occur in the same cycle, chrack wins and chrrdata is used.
- vmemack is high for exactly one cycle per accepted request; there is never more than one outstanding transaction.
- Reset mid-transaction (async):
  - the transaction is dropped;
  - no ack is issued;
  - an in-progress RAM write may or may not land.
- A change of mirror while busy affects only later requests.
- vmemreq dropping before ack is a protocol violation; the latched transaction completes anyway.

Optional Feature:
- PPUVMEM_FOURSCREEN_EN.
  - Defined: nametable RAM is 4 KB and the `MIRSINGLE1 encoding instead selects four-screen mode, RAM index = addr[11:0]. All other modes keep pages 0/1.
  - Undefined: RAM is 2 KB and the mode behaves as single-screen high.

Decomposition:
- Mirror-mode encodings `MIRHORZ=0, `MIRVERT=1, `MIRSINGLE0=2, `MIRSINGLE1=3 go in dat.vh alongside the existing `VRAMINC/`PATTAB defines.
- One sub-module, vram_nt: single-port synchronous RAM with registered read. 11-bit address, or 12-bit with the macro. Write-first behaviour is not relied on.

Test Plan:
- Vertical mirroring: write 8'hA5 to $2005, read $2805 -> 8'hA5. Read $2405 -> not 8'hA5 (preloaded 8'h00). Ack 2 cycles after read acceptance.
- Horizontal mirroring: write 8'h3C to $2400, read $2000 -> 8'h3C. Read $3C00 -> same as $2C00, not 8'h3C.
- CHR read of $1ABC with chrack 5 cycles later, chrrdata = 8'h7E:
  - chraddr = 13'h1ABC, chrwr = 0;
  - vmemrdata = 8'h7E;
  - one vmemack the cycle after chrack.
- CHR timeout with CHR_TIMEOUT=8, chrack never asserted -> chrreq drops, vmemrdata = 8'hFF, single ack after 8 wait cycles. A following request is served normally.
- Back-to-back: initiator drops req the cycle after ack and re-raises it the next cycle -> each request acked exactly once, no double accept in the ack cycle.
- Reset asserted in CHRWAIT -> chrreq = 0 and vmemack = 0 immediately. Next request after reset completes correctly.
- With PPUVMEM_FOURSCREEN_EN and mode 3: writes to $2000/$2400/$2800/$2C00 with distinct values -> all four read back distinct.
